// File: rtl/iob_gray_decoder.sv
// Gray-to-binary sample decoder: tracks forward step, wrap-around, illegal
// multi-bit transitions and a saturating total of steps between captures.
module iob_gray_decoder #(
    parameter int W     = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             cke_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [W-1:0]     gray_i,
    input  logic             err_clr_i,
    output logic [W-1:0]     bin_o,
    output logic             valid_o,
    output logic             upd_o,
    output logic [W-1:0]     step_o,
    output logic             wrap_o,
    output logic             err_o,
    output logic [CNT_W-1:0] total_o
);

    typedef enum logic {
        EMPTY = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     gray_q;
    logic [W-1:0]     gray_d;
    logic [W-1:0]     bin_d;
    logic             valid_d;
    logic             upd_d;
    logic [W-1:0]     step_d;
    logic             wrap_d;
    logic             err_d;
    logic [CNT_W-1:0] total_d;

    logic [W-1:0]     b_new;
    logic [W-1:0]     diff;
    logic             multi_bit;
    logic [CNT_W:0]   sum;

    always_comb begin
        b_new        = '0;
        b_new[W-1]   = gray_i[W-1];
        for (int unsigned i = 1; i < W; i++) begin
            b_new[W-1-i] = b_new[W-i] ^ gray_i[W-1-i];
        end
    end

    // More than one set bit in the difference <=> clearing the lowest set bit leaves something.
    assign diff      = gray_i ^ gray_q;
    assign multi_bit = |(diff & (diff - W'(1)));

    always_comb begin
        state_d = state_q;
        gray_d  = gray_q;
        bin_d   = bin_o;
        valid_d = valid_o;
        upd_d   = 1'b0;
        step_d  = step_o;
        wrap_d  = 1'b0;
        err_d   = err_o;
        total_d = total_o;
        sum     = '0;

        if (err_clr_i) begin
            err_d = 1'b0;
        end

        if (en_i) begin
            upd_d  = 1'b1;
            gray_d = gray_i;
            bin_d  = b_new;
            case (state_q)
                EMPTY: begin
                    valid_d = 1'b1;
                    step_d  = '0;
                    state_d = TRACK;
                end
                TRACK: begin
                    step_d = b_new - bin_o;
                    wrap_d = (b_new < bin_o);
                    sum    = {1'b0, total_o} + (CNT_W+1)'(step_d);
                    total_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
                    if (multi_bit) begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i) begin
                state_q <= EMPTY;
                gray_q  <= '0;
                bin_o   <= '0;
                valid_o <= 1'b0;
                upd_o   <= 1'b0;
                step_o  <= '0;
                wrap_o  <= 1'b0;
                err_o   <= 1'b0;
                total_o <= '0;
            end else begin
                state_q <= state_d;
                gray_q  <= gray_d;
                bin_o   <= bin_d;
                valid_o <= valid_d;
                upd_o   <= upd_d;
                step_o  <= step_d;
                wrap_o  <= wrap_d;
                err_o   <= err_d;
                total_o <= total_d;
            end
        end
    end

endmodule

// File: tb/tb_iob_gray_decoder.sv
// Randomized bench for iob_gray_decoder (W=4) with a behavioural model;
// two instances share stimulus to exercise CNT_W=16 and a saturating CNT_W=4.
module tb_iob_gray_decoder;

    logic       clk = 1'b0;
    logic       cke, rst, en, err_clr;
    logic [3:0] gray;

    logic [3:0]  a_bin, a_step, b_bin, b_step;
    logic        a_valid, a_upd, a_wrap, a_err;
    logic        b_valid, b_upd, b_wrap, b_err;
    logic [15:0] a_total;
    logic [3:0]  b_total;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    bit m_seen;
    int m_prev_gray, m_bin, m_step, m_total16, m_total4;
    bit m_valid, m_upd, m_wrap, m_err;

    always #5 clk = ~clk;

    iob_gray_decoder #(.W(4), .CNT_W(16)) dut_a (
        .clk_i(clk), .cke_i(cke), .rst_i(rst), .en_i(en), .gray_i(gray),
        .err_clr_i(err_clr), .bin_o(a_bin), .valid_o(a_valid), .upd_o(a_upd),
        .step_o(a_step), .wrap_o(a_wrap), .err_o(a_err), .total_o(a_total)
    );

    iob_gray_decoder #(.W(4), .CNT_W(4)) dut_b (
        .clk_i(clk), .cke_i(cke), .rst_i(rst), .en_i(en), .gray_i(gray),
        .err_clr_i(err_clr), .bin_o(b_bin), .valid_o(b_valid), .upd_o(b_upd),
        .step_o(b_step), .wrap_o(b_wrap), .err_o(b_err), .total_o(b_total)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int g2b(input int g);
        int b = 0;
        for (int k = 0; k < 4; k++) b ^= (g >> k);
        return b & 15;
    endfunction

    function automatic int b2g(input int b);
        return (b ^ (b >> 1)) & 15;
    endfunction

    function automatic void model_edge(input bit c, input bit r, input bit e,
                                       input bit clr, input int g);
        int b, d;
        if (!c) return;
        if (r) begin
            m_seen = 0; m_prev_gray = 0; m_bin = 0; m_step = 0;
            m_total16 = 0; m_total4 = 0;
            m_valid = 0; m_upd = 0; m_wrap = 0; m_err = 0;
            return;
        end
        m_upd = 0;
        m_wrap = 0;
        if (clr) m_err = 0;
        if (e) begin
            b = g2b(g);
            m_upd = 1;
            if (!m_seen) begin
                m_seen = 1; m_valid = 1; m_step = 0;
            end else begin
                d = (b - m_bin + 16) % 16;
                m_step = d;
                m_wrap = (b < m_bin);
                m_total16 = (m_total16 + d > 65535) ? 65535 : m_total16 + d;
                m_total4  = (m_total4 + d > 15) ? 15 : m_total4 + d;
                if ($countones(g ^ m_prev_gray) > 1) m_err = 1;
            end
            m_bin = b;
            m_prev_gray = g;
        end
    endfunction

    task automatic compare_all();
        check("bin",     a_bin,   m_bin);
        check("valid",   a_valid, m_valid);
        check("upd",     a_upd,   m_upd);
        check("step",    a_step,  m_step);
        check("wrap",    a_wrap,  m_wrap);
        check("err",     a_err,   m_err);
        check("total16", a_total, m_total16);
        check("bin_b",   b_bin,   m_bin);
        check("err_b",   b_err,   m_err);
        check("total4",  b_total, m_total4);
    endtask

    task automatic cyc(input bit c, input bit r, input bit e, input bit clr, input int g);
        cke = c; rst = r; en = e; err_clr = clr; gray = 4'(g);
        @(posedge clk);
        model_edge(c, r, e, clr, g);
        #1;
        compare_all();
    endtask

    initial begin
        int b_cur, nb, sel;
        bit c, r, e, clr;
        cke = 1; rst = 1; en = 1; err_clr = 0; gray = 4'd5;
        m_seen = 0; m_prev_gray = 0; m_bin = 0; m_step = 0;
        m_total16 = 0; m_total4 = 0;
        m_valid = 0; m_upd = 0; m_wrap = 0; m_err = 0;

        // reset with a sample presented: sample discarded
        cyc(1, 1, 1, 0, 5);
        check("rst_valid", a_valid, 0);
        check("rst_total", a_total, 0);

        // counting sequence 0,1,2,3
        cyc(1, 0, 1, 0, 4'b0000); check("seq0_step", a_step, 0);
        cyc(1, 0, 1, 0, 4'b0001);
        cyc(1, 0, 1, 0, 4'b0011);
        cyc(1, 0, 1, 0, 4'b0010);
        check("seq_bin", a_bin, 3);
        check("seq_total", a_total, 3);
        check("seq_err", a_err, 0);

        // wrap 15 -> 0
        cyc(1, 0, 1, 0, 4'b1000);
        cyc(1, 0, 1, 0, 4'b0000);
        check("wrap_pulse", a_wrap, 1);
        check("wrap_step", a_step, 1);
        cyc(1, 0, 0, 0, 4'b0000);
        check("wrap_gone", a_wrap, 0);
        check("upd_gone", a_upd, 0);

        // illegal transition 1 -> 5
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 4'b0001);
        cyc(1, 0, 1, 0, 4'b0111);
        check("ill_err", a_err, 1);
        check("ill_step", a_step, 4);
        check("ill_bin", a_bin, 5);
        cyc(1, 0, 1, 0, 4'b0110);
        check("err_sticky", a_err, 1);
        cyc(1, 0, 1, 0, 4'b0110);
        check("repeat_step", a_step, 0);
        check("repeat_upd", a_upd, 1);
        cyc(1, 0, 0, 1, 0);
        check("err_clr", a_err, 0);

        // freeze under cke=0, then clear+new error on same edge
        cyc(0, 0, 1, 1, 4'b1111);
        cyc(0, 1, 1, 0, 4'b1010);
        check("frz_bin", a_bin, 4);
        cyc(1, 0, 1, 1, 4'b0000);
        check("clr_vs_set", a_err, 1);

        // saturation on CNT_W=4
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 4'b0000);
        cyc(1, 0, 1, 0, 4'b1000);
        check("sat_15", b_total, 15);
        cyc(1, 0, 1, 0, 4'b0000);
        check("sat_hold", b_total, 15);
        check("nosat_16", a_total, 16);

        // mid-stream reset with en=1, next capture gives step 0
        cyc(1, 1, 1, 0, 4'b0001);
        check("mrst_valid", a_valid, 0);
        cyc(1, 0, 1, 0, 4'b0011);
        check("mrst_step", a_step, 0);
        check("mrst_bin", a_bin, 2);

        // randomized traffic
        b_cur = 2;
        for (int n = 0; n < 3000; n++) begin
            c   = ($urandom_range(0, 9) != 0);
            r   = ($urandom_range(0, 99) == 0);
            e   = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 6)      nb = (b_cur + 1) % 16;
            else if (sel < 7) nb = b_cur;
            else if (sel < 8) nb = (b_cur + 15) % 16;
            else              nb = $urandom_range(0, 15);
            cyc(c, r, e, clr, b2g(nb));
            if (c && !r && e) b_cur = nb;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
